rmgmt_mem_responder: RTL and testbench
======================================

# rmgmt_mem_responder

Memory responder for the RISC-MGMT memory request channel: accepts `req_mem`/`mem_ren`/`mem_wen` word transfers issued by RISC-MGMT extensions and returns `mem_load`/`mem_busy`. Sits between the pipeline data port and the core data generic bus. Arbitrates extension traffic against the pipeline's own loads/stores and runs one transfer at a time through a small FSM. Applies a starvation guard so neither master is locked out.

## Interface
- `STARVE_LIMIT`, 4: consecutive extension grants allowed while a pipeline request waits (range 1..7).
- `CLK` in 1: clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `rm_req_mem` in 1: extension memory request valid.
- `rm_ren`, `rm_wen` in 1 each: extension read/write strobes.
- `rm_addr` in 32: extension word address.
- `rm_store` in 32: extension write data.
- `rm_load` out 32: extension read data.
- `rm_busy` out 1: extension transfer not yet complete.
- `rm_misaligned` out 1: one-cycle flag; extension address not word aligned.
- `core_ren`, `core_wen` in 1 each: pipeline data strobes.
- `core_addr`, `core_wdata` in 32: pipeline address and write data.
- `core_byte_en` in 4: pipeline byte enables.
- `core_rdata` out 32: pipeline read data.
- `core_busy` out 1: pipeline transfer not complete.
- `bus_addr`, `bus_wdata` out 32: generic bus address and write data.
- `bus_ren`, `bus_wen` out 1: generic bus strobes.
- `bus_byte_en` out 4: generic bus byte enables.
- `bus_rdata` in 32: generic bus read data, valid in the cycle `bus_busy` is low.
- `bus_busy` in 1: generic bus busy.

## Operation
- **Request definitions.** Extension request: `rm_req = rm_req_mem & (rm_ren | rm_wen)`. Pipeline request: `core_req = core_ren | core_wen`.
- **Read/write conflict.** If both strobes are high, the transfer is a write and the read strobe is ignored.
- **FSM states.** IDLE, CORE_XFER, RM_XFER.
- **IDLE arbitration.**
  - `rm_req` with `rm_addr[1:0] != 0`: no bus transfer. `rm_misaligned=1` and `rm_busy=0` in that cycle. Stay in IDLE; the pipeline request is still arbitrated in that cycle.
  - Aligned `rm_req` with `starve_cnt < STARVE_LIMIT`: latch addr, data and direction; go to RM_XFER. If `core_req` is also high, `starve_cnt` increments, saturating at 7.
  - `core_req`, with no eligible extension request or `starve_cnt == STARVE_LIMIT`: latch addr, data, byte enables and direction; go to CORE_XFER; clear `starve_cnt`.
- **CORE_XFER / RM_XFER.**
  - Bus outputs are driven from the latched registers; the extension uses `bus_byte_en = 4'hF`.
  - Strobes and address are held until `bus_busy == 0`. That cycle completes the transfer and the FSM returns to IDLE.
- **Read completion.** On a read, `bus_rdata` is captured into the owner's load register at the completing edge.
  - `rm_load` = `bus_rdata` in the RM_XFER read-completion cycle, otherwise the register. `core_rdata` behaves the same way.
  - The registers hold their value until the next read by the same master; writes do not change them.
- **Busy outputs.**
  - `rm_busy = rm_req & ~misaligned & ~(state==RM_XFER & ~bus_busy)`.
  - `core_busy = core_req & ~(state==CORE_XFER & ~bus_busy)`.
- **Request dropped mid-transfer.** A generic-bus transfer cannot be aborted. If the requester drops its request during XFER, the transfer still runs to completion. Read data is still captured, but busy is not reported for the dropped request.
- **Back-to-back.** A requester that holds its request after completion is re-arbitrated in the next IDLE cycle as a new transfer. Masters must drop their request in the cycle after `busy` falls.

## Timing
- **Reset values.** State IDLE; `starve_cnt` 0; both load registers 0.
  - `bus_ren`, `bus_wen` 0; `bus_addr`, `bus_wdata` 0; `bus_byte_en` 0.
  - `rm_misaligned` 0.
  - `rm_busy`, `core_busy` combinational as defined above (0 when idle).
- **Mid-transfer reset.** `RST` asserted during XFER drops the bus strobes immediately (asynchronous) and discards the transfer.
- **Latency.** A request sampled in IDLE at cycle 0 drives the bus from cycle 1. With zero wait states it completes in cycle 1, so `busy` is high for exactly 1 cycle. Each bus wait state adds one cycle.
- **Bus turnaround.** One IDLE cycle between consecutive transfers; strobes are low in that cycle.
- **Misaligned requests.** Resolved combinationally in the request cycle (0-cycle latency).

## Test plan
- **Extension read.** Aligned read `rm_addr=0x100`, bus returns `0xDEADBEEF` after 2 wait states.
  - Bus shows `ren` at `0x100` with `byte_en=F` for 3 cycles.
  - `rm_busy` is high for 3 cycles, then low with `rm_load=0xDEADBEEF`; the value holds afterwards.
- **Simultaneous requests.** Extension write (`0x200`, `0x55`) and pipeline read (`0x300`) raised in the same cycle.
  - The extension write goes first with `core_busy` held high.
  - After one IDLE cycle the pipeline read runs; `starve_cnt` reads 1, then 0.
- **Starvation guard.** `STARVE_LIMIT=2`; extension re-requests continuously while a pipeline request waits.
  - Exactly 2 extension grants, then the pipeline is granted, then the extension again.
- **Misaligned address.** Extension read at `0x103`.
  - `rm_misaligned=1` and `rm_busy=0` in the same cycle; no bus strobe; FSM stays IDLE.
- **Reset mid-transfer.** Assert `RST` during RM_XFER while `bus_busy=1`.
  - Strobes drop the same cycle; `rm_load=0`; after release an extension read is served normally.
- **Dropped request.** Extension drops `rm_req_mem` mid-read.
  - The bus transfer still completes; `rm_busy` is 0 from the drop onward; `rm_load` captures the returned data.

Source files
------------

// File: rtl/rmgmt_mem_responder.sv
// rmgmt_mem_responder: arbitrates RISC-MGMT extension and pipeline word transfers onto the generic data bus
module rmgmt_mem_responder #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        rm_req_mem,
  input  logic        rm_ren,
  input  logic        rm_wen,
  input  logic [31:0] rm_addr,
  input  logic [31:0] rm_store,
  output logic [31:0] rm_load,
  output logic        rm_busy,
  output logic        rm_misaligned,
  input  logic        core_ren,
  input  logic        core_wen,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [3:0]  core_byte_en,
  output logic [31:0] core_rdata,
  output logic        core_busy,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_ren,
  output logic        bus_wen,
  output logic [3:0]  bus_byte_en,
  input  logic [31:0] bus_rdata,
  input  logic        bus_busy
);
  typedef enum logic [1:0] {IDLE, CORE_XFER, RM_XFER} state_t;
  state_t      state_q, state_d;
  logic [2:0]  starve_q, starve_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0] rm_load_q, rm_load_d, core_load_q, core_load_d;
  logic [3:0]  be_q, be_d;
  logic        wr_q, wr_d;
  logic        rm_req, core_req, misaligned, rm_ok, done, rm_rd_done, core_rd_done;
  // request decode, alignment check and completion detection
  always_comb begin
    rm_req       = rm_req_mem & (rm_ren | rm_wen);
    core_req     = core_ren | core_wen;
    misaligned   = (state_q == IDLE) & rm_req & (rm_addr[1:0] != 2'b00);
    rm_ok        = rm_req & ~misaligned & (starve_q < 3'(STARVE_LIMIT));
    done         = (state_q != IDLE) & ~bus_busy;
    rm_rd_done   = (state_q == RM_XFER) & done & ~wr_q;
    core_rd_done = (state_q == CORE_XFER) & done & ~wr_q;
  end
  // state, latched transfer and load registers; reset discards any transfer in flight
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      starve_q    <= 3'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      be_q        <= 4'd0;
      wr_q        <= 1'b0;
      rm_load_q   <= 32'd0;
      core_load_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      wr_q        <= wr_d;
      rm_load_q   <= rm_load_d;
      core_load_q <= core_load_d;
    end
  end
  // arbitration in IDLE (extension first unless the pipeline has waited too long), return to IDLE on completion
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    wr_d        = wr_q;
    rm_load_d   = rm_rd_done ? bus_rdata : rm_load_q;
    core_load_d = core_rd_done ? bus_rdata : core_load_q;
    if (state_q == IDLE) begin
      if (rm_ok) begin
        state_d  = RM_XFER;
        addr_d   = rm_addr;
        wdata_d  = rm_store;
        be_d     = 4'hF;
        wr_d     = rm_wen;
        starve_d = (core_req && starve_q != 3'd7) ? starve_q + 3'd1 : starve_q;
      end else if (core_req) begin
        state_d  = CORE_XFER;
        addr_d   = core_addr;
        wdata_d  = core_wdata;
        be_d     = core_byte_en;
        wr_d     = core_wen;
        starve_d = 3'd0;
      end
    end else if (done) begin
      state_d = IDLE;
    end
  end
  // bus drive from latched transfer, busy flags and read-data bypass in the completion cycle
  always_comb begin
    bus_ren       = (state_q != IDLE) & ~wr_q;
    bus_wen       = (state_q != IDLE) & wr_q;
    bus_addr      = addr_q;
    bus_wdata     = wdata_q;
    bus_byte_en   = be_q;
    rm_misaligned = misaligned;
    rm_busy       = rm_req & ~misaligned & ~((state_q == RM_XFER) & done);
    core_busy     = core_req & ~((state_q == CORE_XFER) & done);
    rm_load       = rm_rd_done ? bus_rdata : rm_load_q;
    core_rdata    = core_rd_done ? bus_rdata : core_load_q;
  end
endmodule

// File: tb/tb_rmgmt_mem_responder.sv
// tb_rmgmt_mem_responder: directed and randomized checks against a transaction-level reference model
module tb_rmgmt_mem_responder;
  localparam int LIM = 2;
  logic        CLK = 1'b0;
  logic        RST;
  logic        rm_req_mem, rm_ren, rm_wen;
  logic [31:0] rm_addr, rm_store, rm_load;
  logic        rm_busy, rm_misaligned;
  logic        core_ren, core_wen;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic [3:0]  core_byte_en;
  logic        core_busy;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_ren, bus_wen, bus_busy;
  logic [3:0]  bus_byte_en;
  int n_chk = 0;
  int n_fail = 0;
  int          m_own;
  logic [31:0] m_addr, m_wdata, m_rml, m_crl;
  logic [3:0]  m_be;
  logic        m_wr;
  int          m_cnt;
  logic [31:0] q[$];
  rmgmt_mem_responder #(.STARVE_LIMIT(LIM)) dut (
    .CLK(CLK), .RST(RST),
    .rm_req_mem(rm_req_mem), .rm_ren(rm_ren), .rm_wen(rm_wen),
    .rm_addr(rm_addr), .rm_store(rm_store), .rm_load(rm_load),
    .rm_busy(rm_busy), .rm_misaligned(rm_misaligned),
    .core_ren(core_ren), .core_wen(core_wen), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_byte_en(core_byte_en),
    .core_rdata(core_rdata), .core_busy(core_busy),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ren(bus_ren),
    .bus_wen(bus_wen), .bus_byte_en(bus_byte_en),
    .bus_rdata(bus_rdata), .bus_busy(bus_busy)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic mdl_reset();
    m_own = 0; m_addr = 0; m_wdata = 0; m_be = 0; m_wr = 0; m_cnt = 0; m_rml = 0; m_crl = 0;
  endtask
  // one clock: compare outputs against the model for the applied inputs, then advance the model at the edge
  task automatic step();
    logic rq, cq, mis, dn;
    #1;
    rq  = rm_req_mem & (rm_ren | rm_wen);
    cq  = core_ren | core_wen;
    mis = (m_own == 0) && rq && (rm_addr % 4 != 0);
    dn  = (m_own != 0) && !bus_busy;
    chk("rm_misaligned", rm_misaligned, mis);
    chk("rm_busy", rm_busy, rq && !mis && !(m_own == 2 && dn));
    chk("core_busy", core_busy, cq && !(m_own == 1 && dn));
    chk("bus_ren", bus_ren, m_own != 0 && !m_wr);
    chk("bus_wen", bus_wen, m_own != 0 && m_wr);
    if (m_own != 0) begin
      chk("bus_addr", bus_addr, m_addr);
      chk("bus_wdata", bus_wdata, m_wdata);
      chk("bus_byte_en", bus_byte_en, m_be);
    end
    chk("rm_load", rm_load, (m_own == 2 && dn && !m_wr) ? bus_rdata : m_rml);
    chk("core_rdata", core_rdata, (m_own == 1 && dn && !m_wr) ? bus_rdata : m_crl);
    @(posedge CLK);
    if (m_own != 0) begin
      if (dn) begin
        if (!m_wr && m_own == 2) m_rml = bus_rdata;
        if (!m_wr && m_own == 1) m_crl = bus_rdata;
        m_own = 0;
      end
    end else if (rq && !mis && m_cnt < LIM) begin
      m_own = 2; m_addr = rm_addr; m_wdata = rm_store; m_be = 4'hF; m_wr = rm_wen;
      if (cq) m_cnt = (m_cnt == 7) ? 7 : m_cnt + 1;
    end else if (cq) begin
      m_own = 1; m_addr = core_addr; m_wdata = core_wdata; m_be = core_byte_en; m_wr = core_wen;
      m_cnt = 0;
    end
    @(negedge CLK);
  endtask
  initial begin
    RST = 1'b1;
    rm_req_mem = 0; rm_ren = 0; rm_wen = 0; rm_addr = 0; rm_store = 0;
    core_ren = 0; core_wen = 0; core_addr = 0; core_wdata = 0; core_byte_en = 0;
    bus_rdata = 0; bus_busy = 0;
    mdl_reset();
    @(negedge CLK); #1;
    chk("rst_bus_ren", bus_ren, 0);
    chk("rst_bus_wen", bus_wen, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_bus_be", bus_byte_en, 0);
    chk("rst_misaligned", rm_misaligned, 0);
    chk("rst_rm_load", rm_load, 0);
    chk("rst_core_rdata", core_rdata, 0);
    chk("rst_rm_busy", rm_busy, 0);
    chk("rst_core_busy", core_busy, 0);
    RST = 1'b0;
    @(negedge CLK);
    // extension read with two wait states
    rm_req_mem = 1; rm_ren = 1; rm_addr = 32'h100;
    #1 chk("rd_req_busy", rm_busy, 1);
    step();
    bus_busy = 1;
    #1 chk("rd_ren", bus_ren, 1);
    chk("rd_addr", bus_addr, 32'h100);
    chk("rd_be", bus_byte_en, 4'hF);
    step(); step();
    bus_busy = 0; bus_rdata = 32'hDEADBEEF;
    #1 chk("rd_done_busy", rm_busy, 0);
    chk("rd_done_load", rm_load, 32'hDEADBEEF);
    step();
    rm_req_mem = 0; rm_ren = 0; bus_rdata = 0;
    #1 chk("rd_hold_load", rm_load, 32'hDEADBEEF);
    chk("rd_turn_ren", bus_ren, 0);
    step(); step();
    // simultaneous extension write and pipeline read
    rm_req_mem = 1; rm_wen = 1; rm_addr = 32'h200; rm_store = 32'h55;
    core_ren = 1; core_addr = 32'h300; core_byte_en = 4'h3;
    step();
    #1 chk("sim_wen", bus_wen, 1);
    chk("sim_addr", bus_addr, 32'h200);
    chk("sim_wdata", bus_wdata, 32'h55);
    chk("sim_core_busy", core_busy, 1);
    step();
    rm_req_mem = 0; rm_wen = 0;
    #1 chk("sim_turn_wen", bus_wen, 0);
    chk("sim_turn_ren", bus_ren, 0);
    chk("sim_turn_core_busy", core_busy, 1);
    step();
    bus_rdata = 32'hA5A50001;
    #1 chk("sim_core_ren", bus_ren, 1);
    chk("sim_core_addr", bus_addr, 32'h300);
    chk("sim_core_be", bus_byte_en, 4'h3);
    chk("sim_core_rdata", core_rdata, 32'hA5A50001);
    step();
    core_ren = 0; bus_rdata = 0;
    step();
    // starvation guard: two extension grants, then the pipeline, then the extension again
    rm_req_mem = 1; rm_ren = 1; rm_addr = 32'h400; core_ren = 1; core_addr = 32'h500; core_byte_en = 4'hF;
    for (int i = 0; i < 8; i++) begin
      #1 if (bus_ren) q.push_back(bus_addr);
      step();
    end
    rm_req_mem = 0; rm_ren = 0; core_ren = 0;
    step();
    chk("starve_grants", q.size(), 4);
    chk("starve_g0", q[0], 32'h400);
    chk("starve_g1", q[1], 32'h400);
    chk("starve_g2", q[2], 32'h500);
    chk("starve_g3", q[3], 32'h400);
    // misaligned extension address
    rm_req_mem = 1; rm_ren = 1; rm_addr = 32'h103;
    #1 chk("mis_flag", rm_misaligned, 1);
    chk("mis_busy", rm_busy, 0);
    step();
    rm_req_mem = 0; rm_ren = 0;
    #1 chk("mis_no_ren", bus_ren, 0);
    step();
    // reset during an extension transfer
    rm_req_mem = 1; rm_ren = 1; rm_addr = 32'h100; bus_busy = 1;
    step(); step();
    #1 RST = 1;
    #1 chk("rstx_ren", bus_ren, 0);
    chk("rstx_load", rm_load, 0);
    mdl_reset();
    rm_req_mem = 0; rm_ren = 0; bus_busy = 0;
    @(negedge CLK);
    RST = 0;
    rm_req_mem = 1; rm_ren = 1; rm_addr = 32'h104;
    step();
    bus_rdata = 32'h12345678;
    #1 chk("rstx_after_load", rm_load, 32'h12345678);
    step();
    rm_req_mem = 0; rm_ren = 0;
    step();
    // extension drops its request mid-read
    rm_req_mem = 1; rm_ren = 1; rm_addr = 32'h180; bus_busy = 1;
    step(); step();
    rm_req_mem = 0;
    #1 chk("drop_busy", rm_busy, 0);
    step();
    bus_busy = 0; bus_rdata = 32'hCAFEF00D;
    step();
    rm_ren = 0; bus_rdata = 0;
    #1 chk("drop_load", rm_load, 32'hCAFEF00D);
    step();
    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      rm_req_mem   = ($urandom_range(0, 3) != 0);
      rm_ren       = $urandom_range(0, 1) == 1;
      rm_wen       = $urandom_range(0, 2) == 0;
      rm_addr      = ($urandom() & 32'hFFFFFFFC) | (($urandom_range(0, 4) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
      rm_store     = $urandom();
      core_ren     = $urandom_range(0, 2) == 0;
      core_wen     = $urandom_range(0, 3) == 0;
      core_addr    = $urandom();
      core_wdata   = $urandom();
      core_byte_en = 4'($urandom_range(0, 15));
      bus_busy     = $urandom_range(0, 2) == 0;
      bus_rdata    = $urandom();
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
